// File: rtl/frame_buffer_ctrl.sv
// Small generic FIFO: push/pop handshake, head visible combinationally from registers.
// Latency: push in cycle T is visible at the head in cycle T+1.
// Backpressure: a push while full is refused unless a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic             head_vld,
  output logic [WIDTH-1:0] head_dat,
  output logic [AW:0]      occ
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic             push_ok, pop_ok;

  assign head_vld = (occ != '0);
  assign head_dat = mem[rp];
  assign pop_ok   = pop_rdy & head_vld;
  assign push_ok  = push_vld & ((occ < (AW+1)'(DEPTH)) | pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wp] <= push_dat;
        wp      <= wp + 1'b1;
      end
      if (pop_ok) rp <= rp + 1'b1;
      occ <= occ + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end
endmodule

// Circular SRAM sample buffer emitting overlapping frames of FRAME_LEN samples advanced by HOP.
// Latency: read issued in cycle T appears on out_* in cycle T+2; one idle cycle between frames.
// Backpressure: reads stall when the 2-entry output buffer would overflow; in_ready drops at DEPTH-1 held.
module frame_buffer_ctrl #(
  parameter int DEPTH      = 512,
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int FRAME_LEN  = 256,
  parameter int HOP        = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic                  sram_wr_en,
  output logic [ADDR_WIDTH-1:0] sram_wr_addr,
  output logic [WIDTH-1:0]      sram_wr_data,
  output logic                  sram_rd_en,
  output logic [ADDR_WIDTH-1:0] sram_rd_addr,
  input  logic [WIDTH-1:0]      sram_rd_data
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         CAP      = CW'(DEPTH - 1);
  localparam logic [CW-1:0]         FRAME_C  = CW'(FRAME_LEN);
  localparam logic [CW-1:0]         HOP_C    = CW'(HOP);
  localparam logic [ADDR_WIDTH-1:0] HOP_A    = ADDR_WIDTH'(HOP);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_LEN - 1);

  typedef enum logic {IDLE, READ} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] wr_ptr, frame_base, rd_idx, rd_idx_nxt;
  logic [CW-1:0]         count;
  logic                  inflight, inflight_last;
  logic                  wr_acc, pop, issue, issue_last, advance;
  logic [1:0]            fifo_occ;
  logic [WIDTH:0]        head_dat;

  // One slot is always kept free so wr_ptr can never alias a live read address.
  assign in_ready     = (count < CAP);
  assign wr_acc       = in_valid & in_ready;
  assign sram_wr_en   = wr_acc;
  assign sram_wr_addr = wr_ptr;
  assign sram_wr_data = in_data;

  assign pop          = out_valid & out_ready;
  assign issue_last   = (rd_idx == LAST_IDX);
  assign advance      = issue & issue_last;
  assign sram_rd_en   = issue;
  assign sram_rd_addr = frame_base + rd_idx;

  always_comb begin
    state_nxt  = state;
    rd_idx_nxt = rd_idx;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        rd_idx_nxt = '0;
        if (count >= FRAME_C) state_nxt = READ;
      end
      READ: begin
        // Count the read already in flight so the 2-entry buffer cannot overflow.
        if ((3'(fifo_occ) + 3'(inflight)) < (3'd2 + 3'(pop))) begin
          issue = 1'b1;
          if (issue_last) begin
            rd_idx_nxt = '0;
            state_nxt  = IDLE;
          end else begin
            rd_idx_nxt = rd_idx + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      frame_base    <= '0;
      count         <= '0;
      rd_idx        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else if (clear) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      frame_base    <= '0;
      count         <= '0;
      rd_idx        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state         <= state_nxt;
      rd_idx        <= rd_idx_nxt;
      inflight      <= issue;
      inflight_last <= issue_last;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (advance) frame_base <= frame_base + HOP_A;
      count <= count + CW'(wr_acc) - (advance ? HOP_C : '0);
    end
  end

  sync_fifo #(.WIDTH(WIDTH + 1), .DEPTH(2)) u_out_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .push_vld (inflight),
    .push_dat ({sram_rd_data, inflight_last}),
    .pop_rdy  (out_ready),
    .head_vld (out_valid),
    .head_dat (head_dat),
    .occ      (fifo_occ)
  );

  assign out_data = head_dat[WIDTH:1];
  assign out_last = head_dat[0];
endmodule

// File: doc/frame_buffer_ctrl.md
# frame_buffer_ctrl

Sequences one S2SRAM instance as a circular sample buffer and converts an input sample stream into overlapping analysis frames of FRAME_LEN samples advanced by HOP samples. Sits between the audio sample front-end and the windowing/FFT stage of the mel pipeline. Owns both SRAM ports: the input stream drives the write port, and a frame FSM drives the 1-cycle-latency read port behind a 2-entry output buffer with valid/ready backpressure.

## Interface
- DEPTH, 512, SRAM words; power of two.
- WIDTH, 32, sample width.
- ADDR_WIDTH, $clog2(DEPTH), SRAM address width.
- FRAME_LEN, 256, samples per frame; 1 ≤ FRAME_LEN ≤ DEPTH-1.
- HOP, 128, frame advance; 1 ≤ HOP ≤ FRAME_LEN.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous flush: empties buffer, aborts current frame.
- in_valid / in_ready  in / out  1 / 1  input stream handshake.
- in_data  in  WIDTH  input sample.
- out_valid / out_ready  out / in  1 / 1  frame stream handshake.
- out_data  out  WIDTH  frame sample.
- out_last  out  1  marks final sample of each frame.
- sram_wr_en, sram_wr_addr, sram_wr_data  out  1, ADDR_WIDTH, WIDTH  to SRAM write port.
- sram_rd_en, sram_rd_addr  out  1, ADDR_WIDTH  to SRAM read port.
- sram_rd_data  in  WIDTH  SRAM read data, valid the cycle after sram_rd_en.

## Operation
- Registers: wr_ptr, frame_base (ADDR_WIDTH, wrap mod DEPTH); count (ADDR_WIDTH+1) = samples held from frame_base; rd_idx (0..FRAME_LEN-1); inflight (1 bit = sram_rd_en delayed); 2-entry output FIFO carrying {data, last}.
- Write: in_ready = (count < DEPTH-1). sram_wr_en = in_valid & in_ready; sram_wr_addr = wr_ptr at all times; sram_wr_data = in_data. On accept wr_ptr++.
- Capacity is DEPTH-1, not DEPTH: the SRAM bypasses wr_data whenever rd_addr == wr_addr, regardless of wr_en; keeping count ≤ DEPTH-1 guarantees wr_ptr never equals any address being read.
- FSM IDLE: enter READ when count ≥ FRAME_LEN; rd_idx = 0.
- FSM READ: issue when (fifo_occ + inflight − pop) < 2, pop = out_valid & out_ready. Issue drives sram_rd_en=1, sram_rd_addr = frame_base + rd_idx (mod DEPTH), tags last = (rd_idx == FRAME_LEN-1), rd_idx++.
- On issue of the last sample: frame_base += HOP, count −= HOP, FSM → IDLE (always one IDLE cycle between frames).
- count next = count + write_accept − (HOP if advance); simultaneous write and advance both apply.
- Return: cycle after issue, sram_rd_data plus tag are pushed into FIFO. out_valid = FIFO non-empty; out_data/out_last = FIFO head.
- sram_rd_en low when not issuing; sram_rd_addr don't-care then.
- clear: next cycle wr_ptr, frame_base, count, rd_idx, inflight, FIFO = 0, FSM = IDLE; in-flight read data discarded; write accepted in the clear cycle is dropped.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_last=0, sram_wr_en=0 (in_valid low), sram_rd_en=0, all pointers/counters 0, FSM IDLE.
- Read latency: issue in cycle T → out_valid in cycle T+2.
- First frame: count reaches FRAME_LEN at edge E → READ in cycle E+1, first issue E+1, out_valid E+3.
- Throughput with out_ready held high: 1 sample/cycle within a frame; FRAME_LEN+1 cycles per frame when data is available.
- Backpressure: out_data/out_last stable while out_valid & !out_ready; no sample lost or duplicated; FIFO never overflows.
- Write throughput: 1 sample/cycle while count < DEPTH-1; in_ready falls combinationally-from-registers the cycle count hits DEPTH-1.
- Reset mid-frame: asynchronous, all outputs to reset values immediately.

## Test plan
- DEPTH=16, FRAME_LEN=8, HOP=4; write 0..7, out_ready=1 → out_data 0..7, out_last only on 7, first out_valid 2 cycles after first sram_rd_en.
- Write 0..15 continuously (out_ready=1) → frames 0..7, 4..11, 8..15 in order; no gaps within frames.
- out_ready=0, in_valid held → exactly 15 samples accepted, in_ready=0 thereafter, sram_rd_addr never equals sram_wr_addr during a read; release out_ready → frame 0..7 intact.
- Random out_ready (50%) with continuous input 0..63 → output equals reference model of overlapping frames; out_last every 8th sample.
- clear mid-frame after 3 outputs → no further out_valid until 8 new samples written; next frame contains only post-clear values.
- Assert rst_n low mid-frame → out_valid=0, in_ready=1 same cycle; restart reproduces first test.
